// File: rtl/tt_spine_sel.sv
// Spine select controller: synchronizes the clear/increment/enable pins, keeps the
// address counter and sequences spine_sel/spine_ena so the bus only moves after a guard time.
module tt_spine_sel #(
  parameter int SEL_W     = 9,
  parameter int MAX_ADDR  = 2**SEL_W-1,
  parameter int GUARD_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_clr,
  input  logic             sel_inc,
  input  logic             ena_req,
  output logic [SEL_W-1:0] spine_sel,
  output logic             spine_ena,
  output logic             busy,
  output logic [SEL_W-1:0] cur_addr
);

  typedef enum logic [1:0] {S_OFF, S_SETTLE, S_ON, S_DRAIN} state_t;

  localparam logic [7:0]       GUARD = 8'(GUARD_CYC);
  localparam logic [SEL_W-1:0] MAX_A = SEL_W'(MAX_ADDR);
  localparam logic [SEL_W-1:0] ONE_A = SEL_W'(1);

  logic [2:0]       meta_q, sync_q;
  logic             inc_dly_q;
  logic             clr_s, inc_s, req_s, inc_edge;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [7:0]       timer_q, timer_d;
  logic             ena_q, ena_d;
  state_t           state_q, state_d;

  // Bit order in the synchronizer: {req, inc, clr}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q    <= '0;
      sync_q    <= '0;
      inc_dly_q <= 1'b0;
    end else begin
      meta_q    <= {ena_req, sel_inc, sel_clr};
      sync_q    <= meta_q;
      inc_dly_q <= sync_q[1];
    end
  end

  assign clr_s    = sync_q[0];
  assign inc_s    = sync_q[1];
  assign req_s    = sync_q[2];
  assign inc_edge = inc_s & ~inc_dly_q;

  // Clear wins; an increment edge coinciding with a clear is lost
  always_comb begin
    cnt_d = cnt_q;
    if (clr_s)         cnt_d = '0;
    else if (inc_edge) cnt_d = (cnt_q == MAX_A) ? '0 : cnt_q + ONE_A;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OFF;
      timer_q <= '0;
      sel_q   <= '0;
      ena_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      sel_q   <= sel_d;
      ena_q   <= ena_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    sel_d   = sel_q;
    case (state_q)
      S_OFF: begin
        sel_d = cnt_q;
        if (req_s) begin
          state_d = S_SETTLE;
          timer_d = GUARD;
        end
      end
      S_SETTLE: begin
        if (!req_s || cnt_q != sel_q) state_d = S_OFF;
        else if (timer_q == 8'd1)     state_d = S_ON;
        else                          timer_d = timer_q - 8'd1;
      end
      S_ON: begin
        if (!req_s || cnt_q != sel_q) begin
          state_d = S_DRAIN;
          timer_d = GUARD;
        end
      end
      S_DRAIN: begin
        // Requests and address moves are deliberately ignored until OFF
        if (timer_q == 8'd1) state_d = S_OFF;
        else                 timer_d = timer_q - 8'd1;
      end
      default: state_d = S_OFF;
    endcase
  end

  always_comb begin
    ena_d = (state_d == S_ON);
    busy  = (state_q == S_SETTLE) || (state_q == S_DRAIN);
  end

  assign spine_sel = sel_q;
  assign spine_ena = ena_q;
  assign cur_addr  = cnt_q;

endmodule

// File: tb/tb_tt_spine_sel.sv
// Directed-vector bench for tt_spine_sel, with a small-wrap second instance sharing the pins.
module tb_tt_spine_sel;

  localparam int GUARD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_clr, sel_inc, ena_req;
  logic [8:0] spine_sel, cur_addr, w_sel, w_addr;
  logic       spine_ena, busy, w_ena, w_busy;

  int n_vec = 0;
  int n_err = 0;
  int viol  = 0;

  tt_spine_sel #(.SEL_W(9), .MAX_ADDR(511), .GUARD_CYC(GUARD)) dut (
    .clk(clk), .rst(rst), .sel_clr(sel_clr), .sel_inc(sel_inc), .ena_req(ena_req),
    .spine_sel(spine_sel), .spine_ena(spine_ena), .busy(busy), .cur_addr(cur_addr)
  );

  tt_spine_sel #(.SEL_W(9), .MAX_ADDR(7), .GUARD_CYC(GUARD)) u_wrap (
    .clk(clk), .rst(rst), .sel_clr(sel_clr), .sel_inc(sel_inc), .ena_req(ena_req),
    .spine_sel(w_sel), .spine_ena(w_ena), .busy(w_busy), .cur_addr(w_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    int         n_inc;
    logic       req;
    int         wt;
    logic [8:0] e_addr;
    logic [8:0] e_sel;
    logic       e_ena;
    logic       e_busy;
  } vec_t;

  vec_t vt[7];

  // Select-bus stability monitor: a change needs GUARD+1 preceding enable-low samples
  int         zrun_a = 255, zrun_b = 255;
  logic [8:0] prev_a = '0, prev_b = '0;
  always @(negedge clk) begin
    if (rst) begin
      zrun_a = 255; zrun_b = 255;
      prev_a = spine_sel; prev_b = w_sel;
    end else begin
      if (spine_sel != prev_a && (spine_ena || zrun_a < GUARD + 1)) viol++;
      if (w_sel != prev_b && (w_ena || zrun_b < GUARD + 1)) viol++;
      if (busy && spine_ena) viol++;
      if (w_busy && w_ena) viol++;
      zrun_a = spine_ena ? 0 : ((zrun_a < 255) ? zrun_a + 1 : 255);
      zrun_b = w_ena ? 0 : ((zrun_b < 255) ? zrun_b + 1 : 255);
      prev_a = spine_sel;
      prev_b = w_sel;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulses(input int n);
    for (int k = 0; k < n; k++) begin
      sel_inc = 1'b1; wait_cyc(2);
      sel_inc = 1'b0; wait_cyc(2);
    end
  endtask

  // Leaves the controller in OFF with the counter at the requested value
  task automatic setup(input logic clr, input int n_inc);
    ena_req = 1'b0;
    wait_cyc(12);
    if (clr) begin
      sel_clr = 1'b1; wait_cyc(3);
      sel_clr = 1'b0; wait_cyc(3);
    end
    pulses(n_inc);
    wait_cyc(4);
  endtask

  initial begin
    int cnt_m, c8, r, w;
    rst = 1'b1; sel_clr = 1'b0; sel_inc = 1'b0; ena_req = 1'b0;

    //            clr   n  req  wt  addr   sel    ena   busy
    vt[0] = '{1'b1, 3, 1'b1,  6, 9'd3, 9'd3, 1'b0, 1'b1};
    vt[1] = '{1'b1, 3, 1'b1,  7, 9'd3, 9'd3, 1'b1, 1'b0};
    vt[2] = '{1'b1, 3, 1'b1,  2, 9'd3, 9'd3, 1'b0, 1'b0};
    vt[3] = '{1'b1, 3, 1'b1,  3, 9'd3, 9'd3, 1'b0, 1'b1};
    vt[4] = '{1'b0, 2, 1'b1,  7, 9'd5, 9'd5, 1'b1, 1'b0};
    vt[5] = '{1'b1, 0, 1'b0, 10, 9'd0, 9'd0, 1'b0, 1'b0};
    vt[6] = '{1'b1, 9, 1'b1, 20, 9'd9, 9'd9, 1'b1, 1'b0};

    wait_cyc(2);
    chk("rst.sel",  32'(spine_sel), 0);
    chk("rst.ena",  32'(spine_ena), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.addr", 32'(cur_addr), 0);
    rst = 1'b0;
    wait_cyc(2);

    for (int i = 0; i < 7; i++) begin
      setup(vt[i].clr, vt[i].n_inc);
      ena_req = vt[i].req;
      wait_cyc(vt[i].wt);
      chk($sformatf("v%0d.addr", i), 32'(cur_addr),  32'(vt[i].e_addr));
      chk($sformatf("v%0d.sel", i),  32'(spine_sel), 32'(vt[i].e_sel));
      chk($sformatf("v%0d.ena", i),  32'(spine_ena), 32'(vt[i].e_ena));
      chk($sformatf("v%0d.busy", i), 32'(busy),      32'(vt[i].e_busy));
    end

    // Address change while ON: drain, reload, re-enable
    setup(1'b1, 5);
    ena_req = 1'b1;
    wait_cyc(10);
    chk("mv.on", 32'(spine_ena), 1);
    sel_inc = 1'b1;
    wait_cyc(3);
    chk("mv.e3_addr", 32'(cur_addr), 6);
    chk("mv.e3_ena",  32'(spine_ena), 1);
    wait_cyc(1);
    chk("mv.e4_ena",  32'(spine_ena), 0);
    chk("mv.e4_sel",  32'(spine_sel), 5);
    wait_cyc(1);
    sel_inc = 1'b0;
    wait_cyc(3);
    chk("mv.e8_sel",  32'(spine_sel), 5);
    chk("mv.e8_busy", 32'(busy), 0);
    wait_cyc(1);
    chk("mv.e9_sel",  32'(spine_sel), 6);
    chk("mv.e9_busy", 32'(busy), 1);
    wait_cyc(3);
    chk("mv.e12_ena", 32'(spine_ena), 0);
    wait_cyc(1);
    chk("mv.e13_ena", 32'(spine_ena), 1);

    // Request withdrawn during SETTLE
    setup(1'b0, 0);
    ena_req = 1'b1;
    wait_cyc(4);
    chk("ab.busy4", 32'(busy), 1);
    ena_req = 1'b0;
    wait_cyc(2);
    chk("ab.busy6", 32'(busy), 1);
    chk("ab.ena6",  32'(spine_ena), 0);
    wait_cyc(1);
    chk("ab.busy7", 32'(busy), 0);
    for (int k = 0; k < 8; k++) begin
      wait_cyc(1);
      chk($sformatf("ab.ena_%0d", k), 32'(spine_ena), 0);
    end

    // Counter wrap on both instances, then clear overriding an increment edge
    setup(1'b1, 7);
    chk("wr.a7", 32'(cur_addr), 7);
    chk("wr.w7", 32'(w_addr), 7);
    pulses(1); wait_cyc(4);
    chk("wr.a8", 32'(cur_addr), 8);
    chk("wr.w0", 32'(w_addr), 0);
    pulses(503); wait_cyc(4);
    chk("wr.a511", 32'(cur_addr), 511);
    chk("wr.w511", 32'(w_addr), 7);
    pulses(1); wait_cyc(4);
    chk("wr.a0", 32'(cur_addr), 0);
    chk("wr.w00", 32'(w_addr), 0);
    pulses(2); wait_cyc(4);
    sel_clr = 1'b1; wait_cyc(3);
    pulses(1); wait_cyc(4);
    chk("clr.hold_a", 32'(cur_addr), 0);
    chk("clr.hold_w", 32'(w_addr), 0);
    sel_clr = 1'b0; wait_cyc(4);
    chk("clr.after", 32'(cur_addr), 0);

    // Asynchronous reset while enabled on 0x1A5
    setup(1'b1, 9'h1A5);
    ena_req = 1'b1;
    wait_cyc(10);
    chk("ar.ena", 32'(spine_ena), 1);
    chk("ar.sel", 32'(spine_sel), 32'h1A5);
    @(posedge clk); #2 rst = 1'b1; #1;
    chk("ar.ena0",  32'(spine_ena), 0);
    chk("ar.sel0",  32'(spine_sel), 0);
    chk("ar.addr0", 32'(cur_addr), 0);
    chk("ar.busy0", 32'(busy), 0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    wait_cyc(3);
    chk("ar.busy3", 32'(busy), 1);
    wait_cyc(3);
    chk("ar.ena6", 32'(spine_ena), 0);
    wait_cyc(1);
    chk("ar.ena7", 32'(spine_ena), 1);
    chk("ar.sel7", 32'(spine_sel), 0);

    // Random pin stream against a pulse-counting model
    setup(1'b1, 0);
    cnt_m = 0; c8 = 0;
    for (int s = 0; s < 1200; s++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        wait_cyc(2);
        sel_clr = 1'b1; wait_cyc(3);
        sel_clr = 1'b0; wait_cyc(1);
        cnt_m = 0; c8 = 0;
      end else if (r <= 3) begin
        ena_req = ~ena_req;
        wait_cyc($urandom_range(1, 12));
      end else begin
        w = $urandom_range(1, 4);
        sel_inc = 1'b1; wait_cyc(w);
        w = $urandom_range(1, 4);
        sel_inc = 1'b0; wait_cyc(w);
        cnt_m = (cnt_m + 1) % 512;
        c8 = (c8 + 1) % 8;
      end
      if (s % 40 == 39) begin
        wait_cyc(4);
        chk($sformatf("rnd%0d.addr", s), 32'(cur_addr), 32'(cnt_m));
        chk($sformatf("rnd%0d.waddr", s), 32'(w_addr), 32'(c8));
      end
    end
    wait_cyc(4);
    chk("rnd.final_addr", 32'(cur_addr), 32'(cnt_m));
    chk("rnd.final_waddr", 32'(w_addr), 32'(c8));
    chk("invariant_viol", 32'(viol), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
